uart_tx_fifo_drain: RTL and testbench
=====================================

Name: uart_tx_fifo_drain

Overview:
- Downstream consumer of the TX FIFO: pops bytes from the FIFO and serialises each one as a UART 8-N-1 frame (optional even parity) on the tx line.
- Sits between the FIFO (control unit plus register file, combinational read at r_addr) and the tx pin.
- Timing comes from an oversampling baud tick shared with the RX path.

Parameters:
- TICKS_PER_BIT, 16, number of b_tick pulses per UART bit.
- PARITY_EN, 0, 1 inserts an even-parity bit between D7 and stop.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- b_tick  input  1  one-clk-wide baud oversample pulse (TICKS_PER_BIT per bit)
- fifo_empty  input  1  FIFO empty flag
- fifo_rdata  input  8  FIFO head word; valid whenever fifo_empty=0 (first-word fall-through)
- fifo_pop  output  1  one-clk pop strobe to FIFO
- tx  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is in progress
- tx_done  output  1  one-clk pulse at end of stop bit

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; tx=1; tx_busy=0; tx_done=0; fifo_pop=0; tick counter=0; bit index=0; shift register=0.
  - Takes effect immediately, including mid-frame. A byte already popped is discarded and never retransmitted.
- States: IDLE, START, DATA, PARITY (only if PARITY_EN=1), STOP.
- IDLE:
  - tx=1.
  - fifo_pop = (state==IDLE) && !fifo_empty, combinational.
  - In that same cycle: shift register <= fifo_rdata; parity <= ^fifo_rdata; next state START.
  - fifo_pop is therefore high for exactly one clk per byte, never when fifo_empty=1, and never outside IDLE.
- Tick counter:
  - Cleared on every state entry.
  - Increments on each b_tick.
  - The bit ends on the b_tick that occurs while counter==TICKS_PER_BIT-1; that cycle advances state/bit and clears the counter.
  - Bit length is exactly TICKS_PER_BIT tick periods, measured from the first b_tick after state entry (plus sub-tick phase on entry).
- START: tx=0; after one bit time -> DATA, bit index=0.
- DATA:
  - tx=shift[0], LSB first; shift right at each bit end.
  - After bit index 7 -> PARITY if PARITY_EN, else STOP.
  - Bit index is 3 bits and must not wrap into a 9th data bit.
- PARITY: tx=parity (even: total ones in data+parity is even); after one bit time -> STOP.
- STOP:
  - tx=1.
  - At bit end: tx_done=1 for that single clk (registered, visible the following cycle), state -> IDLE.
- tx_busy = (state != IDLE), registered with state.
- Back-to-back:
  - If the FIFO is non-empty on return to IDLE, the pop occurs in the first IDLE cycle.
  - Inter-frame gap is exactly one clk of tx=1 beyond the stop bit.
- b_tick asserted in the same cycle as the IDLE->START transition is ignored (counter is cleared on entry).
- fifo_empty/fifo_rdata changes during START..STOP have no effect on the frame in flight.
- b_tick absent: state holds indefinitely, tx holds its current value.
- FIFO push/pop concurrency: push-while-pop is handled by the FIFO, not this block.

Test Plan:
- Reset/idle: rst pulse, fifo_empty=1, 10 bit-times of b_tick -> tx=1, fifo_pop never asserted, tx_busy=0, tx_done=0.
- Single byte 8'hA5, PARITY_EN=0, b_tick every 651 clk (100 MHz, 9600 baud x16):
  - fifo_pop exactly one clk.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
  - tx_done one pulse; tx_busy high for the whole frame.
- Back-to-back 8'h00, 8'hFF, 8'h3C preloaded:
  - Three pops, one per frame.
  - Frames decoded by the bench monitor match in order.
  - One-clk idle gap between stop and next start; three tx_done pulses.
- Parity, PARITY_EN=1, bytes 8'h01 and 8'h03 -> parity bits 1 and 0 respectively; 11-bit frames.
- Reset mid-frame: assert rst during DATA bit 3 of 8'h5A:
  - tx goes to 1 in the same cycle; tx_busy=0.
  - After release with FIFO empty, no further pops and tx stays 1.
- Empty during frame: FIFO holds one byte and becomes empty after the pop -> frame completes normally, block stays in IDLE with no extra pop.

Source files
------------

// File: rtl/uart_tx_fifo_drain.sv
// UART 8-N-1 transmitter that drains a first-word-fall-through TX FIFO.
// Optional even parity; bit timing from a shared oversampling baud tick.
module uart_tx_fifo_drain #(
  parameter int TICKS_PER_BIT = 16,
  parameter bit PARITY_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int CW =
    (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_BIT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end_d;

  assign bit_end_d = b_tick && (cnt_q == LAST);
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && b_tick)
        cnt_q <= bit_end_d ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          // a tick in the pop cycle is dropped: counter restarts
          if (fifo_pop) begin
            shift_q <= fifo_rdata;
            par_q   <= ^fifo_rdata;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end_d) begin
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (bit_end_d) begin
            shift_q <= {1'b0, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              if (PARITY_EN) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_d) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end_d) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: stimulus queues hand-built frames, per-DUT
// monitors decode the tx line tick by tick and compare.
module tb_uart_tx_fifo_drain;

  localparam int T = 4;
  localparam int P = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic b_tick = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int tdiv = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (tdiv == P - 1) begin
      tdiv   <= 0;
      b_tick <= 1'b1;
    end else begin
      tdiv   <= tdiv + 1;
      b_tick <= 1'b0;
    end
  end

  logic [1:0] emp, pop, txl, busy, done;
  logic [7:0] rdat [2];

  logic [10:0] expq [$];
  int nvec = 0;
  int nerr = 0;
  bit b2b = 1'b0;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  uart_tx_fifo_drain #(.TICKS_PER_BIT(T), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .b_tick(b_tick),
    .fifo_empty(emp[0]), .fifo_rdata(rdat[0]),
    .fifo_pop(pop[0]), .tx(txl[0]),
    .tx_busy(busy[0]), .tx_done(done[0]));

  uart_tx_fifo_drain #(.TICKS_PER_BIT(T), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .b_tick(b_tick),
    .fifo_empty(emp[1]), .fifo_rdata(rdat[1]),
    .fifo_pop(pop[1]), .tx(txl[1]),
    .tx_busy(busy[1]), .tx_done(done[1]));

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int NB = (g == 1) ? 11 : 10;
    logic [7:0] mem [16];
    int rdp = 0;
    int wrp = 0;
    bit pend = 1'b0;
    bit inf = 1'b0;
    bit stable = 1'b1;
    bit busyok = 1'b1;
    bit prevtx = 1'b1;
    bit prevdone = 1'b0;
    bit havedone = 1'b0;
    int n = 0;
    int k = 0;
    int lastdone = 0;
    int donecnt = 0;
    int popcnt = 0;
    logic [10:0] bits = '0;

    assign emp[g]  = (rdp == wrp);
    assign rdat[g] = mem[rdp % 16];

    always @(negedge clk) pend = pop[g];
    always @(posedge clk) if (pend) rdp <= rdp + 1;

    always @(negedge clk) begin
      if (rst) begin
        inf = 1'b0;
        havedone = 1'b0;
        prevtx = 1'b1;
        prevdone = 1'b0;
      end else begin
        if (pop[g]) begin
          popcnt++;
          chk("pop_legal", {emp[g], busy[g]}, 0);
        end
        if (done[g]) begin
          donecnt++;
          chk("done_width", prevdone, 0);
          havedone = 1'b1;
          lastdone = cyc;
        end
        if (!inf && prevtx && !txl[g]) begin
          inf = 1'b1;
          n = 0;
          bits = '0;
          stable = 1'b1;
          busyok = 1'b1;
          if (b2b && havedone) chk("gap", cyc - lastdone, 1);
        end
        if (inf) begin
          if (!busy[g]) busyok = 1'b0;
          if (b_tick) begin
            n++;
            k = (n - 1) / T;
            if ((n - 1) % T == 0) bits[k] = txl[g];
            else if (bits[k] !== txl[g]) stable = 1'b0;
            if (n == NB * T) begin
              inf = 1'b0;
              chk("busy_frame", busyok, 1);
              chk("bit_len", stable, 1);
              if (expq.size() == 0)
                chk("frame_expected", expq.size(), 1);
              else
                chk($sformatf("frame%0d", g), bits, expq.pop_front());
            end
          end
        end
        prevtx = txl[g];
        prevdone = done[g];
      end
    end
  end

  task automatic push(int g, logic [7:0] b);
    if (g == 0) begin
      gm[0].mem[gm[0].wrp % 16] = b;
      gm[0].wrp++;
    end else begin
      gm[1].mem[gm[1].wrp % 16] = b;
      gm[1].wrp++;
    end
  endtask

  function automatic int pcnt(int g);
    return (g == 0) ? gm[0].popcnt : gm[1].popcnt;
  endfunction

  function automatic int dcnt(int g);
    return (g == 0) ? gm[0].donecnt : gm[1].donecnt;
  endfunction

  task automatic wait_done(int g, int tgt);
    int c = 0;
    while (dcnt(g) < tgt && c < 5000) begin
      @(negedge clk);
      c++;
    end
    chk("done_count", dcnt(g), tgt);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", txl, 3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop", pop, 0);
    rst = 1'b0;
    repeat (10 * T * P) @(negedge clk);
    chk("idle_tx", txl, 3);
    chk("idle_busy", busy, 0);
    chk("idle_pops", pcnt(0) + pcnt(1), 0);
    chk("idle_done", dcnt(0) + dcnt(1), 0);

    // single byte: 0,1,0,1,0,0,1,0,1,1
    expq.push_back(11'h34A);
    push(0, 8'hA5);
    wait_done(0, 1);
    chk("a5_pops", pcnt(0), 1);

    // back-to-back preload
    expq.push_back(11'h200);
    expq.push_back(11'h3FE);
    expq.push_back(11'h278);
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h3C);
    repeat (2) @(negedge clk);
    #1 b2b = 1'b1;
    wait_done(0, 4);
    b2b = 1'b0;
    chk("b2b_pops", pcnt(0), 4);

    // even parity: 01 -> 1, 03 -> 0
    expq.push_back(11'h602);
    expq.push_back(11'h406);
    push(1, 8'h01);
    push(1, 8'h03);
    wait_done(1, 2);
    chk("par_pops", pcnt(1), 2);

    // reset during data bit 3
    push(0, 8'h5A);
    c = 0;
    while (txl[0] && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("mid_start", txl[0], 0);
    c = 0;
    for (int i = 0; i < 2000 && c < 4 * T + 2; i++) begin
      @(negedge clk);
      if (b_tick) c++;
    end
    chk("mid_busy1", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_tx", txl[0], 1);
    chk("mid_busy0", busy[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20 * T * P) @(negedge clk);
    chk("mid_pops", pcnt(0), 5);
    chk("mid_done", dcnt(0), 4);
    chk("mid_txidle", txl[0], 1);
    chk("mid_idle_busy", busy[0], 0);

    // single byte, FIFO empty after pop
    expq.push_back(11'h386);
    push(0, 8'hC3);
    wait_done(0, 5);
    repeat (2 * T * P) @(negedge clk);
    chk("empty_pops", pcnt(0), 6);
    chk("empty_busy", busy[0], 0);
    chk("empty_tx", txl[0], 1);
    chk("exp_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
